// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared constants and lane state encoding for the PHY RX symbol-lock path
//   COM_SYM        : comma symbol hunted for on every lane
//   *_W            : widths of the per-lane phase, COM and gap counters
//   lane_state_e   : HUNT / CHECK / SYNC lane states
package phy_rx_pkg;

  localparam logic [7:0] COM_SYM   = 8'hBC;
  localparam int         PHASE_W   = 3;
  localparam int         COM_CNT_W = 4;
  localparam int         GAP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SYNC  = 2'd2
  } lane_state_e;

endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// rtl/phy_rx_sync_ctrl_if.sv - lane inputs and aligned-byte outputs of the two-lane RX sync controller
//   enable           : lanes run while high, forced to HUNT when low
//   D_0, D_1         : serial lane bits, MSB first
//   data_0, data_1   : last aligned byte per lane
//   valid_0, valid_1 : one-cycle pulse when data_x updates
//   sync_0, sync_1   : lane locked
//   rx_active        : both lanes locked and enabled (registered)
//   master drives the lanes, slave is the controller
interface phy_rx_sync_ctrl_if;

  logic       enable;
  logic       D_0;
  logic       D_1;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       valid_0;
  logic       valid_1;
  logic       sync_0;
  logic       sync_1;
  logic       rx_active;

  modport master (
    output enable, D_0, D_1,
    input  data_0, data_1, valid_0, valid_1, sync_0, sync_1, rx_active
  );

  modport slave (
    input  enable, D_0, D_1,
    output data_0, data_1, valid_0, valid_1, sync_0, sync_1, rx_active
  );

endinterface

// File: rtl/phy_rx_lane_sync.sv
// rtl/phy_rx_lane_sync.sv - one lane: bit shifter, COM hunt, lock/loss FSM, aligned byte output
//   clk, reset : clock, asynchronous active-low reset
//   enable_i   : low forces HUNT, clears counters, valid and sync; shifter holds
//   d_i        : serial lane bit, MSB first
//   data_o     : last presented aligned byte
//   valid_o    : one-cycle pulse when data_o updates
//   sync_o     : lane locked
//   PHY_RX_COM_STRIP_EN : when defined, COM bytes in SYNC are not presented
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter int SYNC_COMS  = 4,
  parameter int LOSS_BYTES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       d_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       sync_o
);

  localparam logic [COM_CNT_W-1:0] SYNC_TARGET = COM_CNT_W'(SYNC_COMS);
  localparam logic [GAP_CNT_W-1:0] LOSS_TARGET = GAP_CNT_W'(LOSS_BYTES);

  lane_state_e          state_q;
  logic [7:0]           sr_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [COM_CNT_W-1:0] com_cnt_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 sync_q;

  logic                 is_com;
  logic                 at_boundary;
  logic [COM_CNT_W-1:0] com_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_d;

  assign is_com      = (sr_q == COM_SYM);
  // Phase is zeroed on the edge that first sees a COM, so phase 7 lands
  // exactly when the next full byte sits in the shifter.
  assign at_boundary = (phase_q == '1);
  assign com_cnt_d   = com_cnt_q + COM_CNT_W'(1);
  assign gap_cnt_d   = gap_cnt_q + GAP_CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      sr_q      <= '0;
      phase_q   <= '0;
      com_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
    end else if (!enable_i) begin
      state_q   <= ST_HUNT;
      phase_q   <= '0;
      com_cnt_q <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sr_q    <= {sr_q[6:0], d_i};
      phase_q <= phase_q + PHASE_W'(1);
      valid_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          if (is_com) begin
            state_q   <= ST_CHECK;
            com_cnt_q <= COM_CNT_W'(1);
            phase_q   <= '0;
          end
        end
        ST_CHECK: begin
          if (at_boundary) begin
            if (is_com) begin
              com_cnt_q <= com_cnt_d;
              if (com_cnt_d == SYNC_TARGET) begin
                state_q   <= ST_SYNC;
                sync_q    <= 1'b1;
                gap_cnt_q <= '0;
              end
            end else begin
              // Hunting resumes on the next shifted window, not this byte.
              state_q   <= ST_HUNT;
              com_cnt_q <= '0;
            end
          end
        end
        ST_SYNC: begin
          if (at_boundary) begin
            if (is_com) begin
              gap_cnt_q <= '0;
`ifndef PHY_RX_COM_STRIP_EN
              data_q    <= sr_q;
              valid_q   <= 1'b1;
`endif
            end else if (gap_cnt_d == LOSS_TARGET) begin
              // The byte that exhausts the gap budget is not presented.
              state_q   <= ST_HUNT;
              sync_q    <= 1'b0;
              gap_cnt_q <= '0;
              com_cnt_q <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_d;
              data_q    <= sr_q;
              valid_q   <= 1'b1;
            end
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// rtl/phy_rx_sync_ctrl.sv - two-lane RX symbol-lock controller: lane instances plus rx_active gate
//   clk, reset : clock, asynchronous active-low reset
//   bus        : phy_rx_sync_ctrl_if slave (enable, D_x in; data_x, valid_x, sync_x, rx_active out)
//   PHY_RX_COM_STRIP_EN : when defined, COM bytes in SYNC are not presented on data_x/valid_x
module phy_rx_sync_ctrl #(
  parameter int SYNC_COMS  = 4,
  parameter int LOSS_BYTES = 16
) (
  input  logic               clk,
  input  logic               reset,
  phy_rx_sync_ctrl_if.slave  bus
);

  logic rx_active_q;

  phy_rx_lane_sync #(.SYNC_COMS(SYNC_COMS), .LOSS_BYTES(LOSS_BYTES)) u_lane0 (
    .clk      (clk),
    .reset    (reset),
    .enable_i (bus.enable),
    .d_i      (bus.D_0),
    .data_o   (bus.data_0),
    .valid_o  (bus.valid_0),
    .sync_o   (bus.sync_0)
  );

  phy_rx_lane_sync #(.SYNC_COMS(SYNC_COMS), .LOSS_BYTES(LOSS_BYTES)) u_lane1 (
    .clk      (clk),
    .reset    (reset),
    .enable_i (bus.enable),
    .d_i      (bus.D_1),
    .data_o   (bus.data_1),
    .valid_o  (bus.valid_1),
    .sync_o   (bus.sync_1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_active_q <= 1'b0;
    end else begin
      rx_active_q <= bus.sync_0 & bus.sync_1 & bus.enable;
    end
  end

  assign bus.rx_active = rx_active_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// tb/tb_phy_rx_sync_ctrl.sv - self-checking bench for phy_rx_sync_ctrl
module tb_phy_rx_sync_ctrl;

`ifdef PHY_RX_COM_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif
  localparam logic [7:0] K = 8'hBC;

  typedef struct {
    logic [7:0] data;
    int         at_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  phy_rx_sync_ctrl_if bus ();

  phy_rx_sync_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every expected presentation carries the edge it must appear on.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q0.size() != 0 && q0[0].at_cyc <= cyc) begin
      e = q0.pop_front();
      n_cmp++;
      if (bus.valid_0 !== 1'b1 || bus.data_0 !== e.data || e.at_cyc != cyc) begin
        n_err++;
        $display("FAIL lane0_byte: valid=%b data=%h edge=%0d, required valid=1 data=%h edge=%0d",
                 bus.valid_0, bus.data_0, cyc, e.data, e.at_cyc);
      end
    end else if (bus.valid_0 !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL lane0_unexpected_valid: valid=%b data=%h edge=%0d, required valid=0",
               bus.valid_0, bus.data_0, cyc);
    end
    if (q1.size() != 0 && q1[0].at_cyc <= cyc) begin
      e = q1.pop_front();
      n_cmp++;
      if (bus.valid_1 !== 1'b1 || bus.data_1 !== e.data || e.at_cyc != cyc) begin
        n_err++;
        $display("FAIL lane1_byte: valid=%b data=%h edge=%0d, required valid=1 data=%h edge=%0d",
                 bus.valid_1, bus.data_1, cyc, e.data, e.at_cyc);
      end
    end else if (bus.valid_1 !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL lane1_unexpected_valid: valid=%b data=%h edge=%0d, required valid=0",
               bus.valid_1, bus.data_1, cyc);
    end
  end

  // Drives one byte per lane MSB first; snapshots sync after the first bit edge
  // (the previous byte's boundary) and rx_active after the first and second.
  task automatic drive_byte(input logic [7:0] b0, input logic [7:0] b1, input bit p0, input bit p1,
                            output logic s0, output logic s1, output logic ra0, output logic ra1);
    for (int i = 7; i >= 0; i--) begin
      bus.D_0 = b0[i];
      bus.D_1 = b1[i];
      @(posedge clk); #1;
      if (i == 7) begin s0 = bus.sync_0; s1 = bus.sync_1; ra0 = bus.rx_active; end
      if (i == 6) ra1 = bus.rx_active;
    end
    if (p0) q0.push_back('{b0, cyc + 1});
    if (p1) q1.push_back('{b1, cyc + 1});
  endtask

  task automatic apply_reset();
    bus.enable = 1'b0; bus.D_0 = 1'b0; bus.D_1 = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    bus.enable = 1'b1;
  endtask

  task automatic lock_both();
    logic s0, s1, r0, r1;
    apply_reset();
    for (int k = 0; k < 4; k++) drive_byte(K, K, 1'b0, 1'b0, s0, s1, r0, r1);
  endtask

  task automatic drain();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.D_0 = 1'b0; bus.D_1 = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if ({bus.data_0, bus.data_1} !== 16'h0000) begin
      n_err++; $display("FAIL reset_data: %h %h, required 00 00", bus.data_0, bus.data_1);
    end
    n_cmp++;
    if ({bus.valid_0, bus.valid_1, bus.sync_0, bus.sync_1, bus.rx_active} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: v0 v1 s0 s1 ra = %b%b%b%b%b, required 00000",
                        bus.valid_0, bus.valid_1, bus.sync_0, bus.sync_1, bus.rx_active);
    end
    reset = 1'b1;
    bus.enable = 1'b1;
  endtask

  task automatic test_lock();
    logic s0, s1, r0, r1;
    for (int k = 0; k < 4; k++) begin
      drive_byte(K, K, 1'b0, 1'b0, s0, s1, r0, r1);
      if (k > 0) begin
        n_cmp++;
        if ({s0, s1} !== 2'b00) begin
          n_err++; $display("FAIL lock_early_sync: byte %0d sync=%b%b, required 00", k, s0, s1);
        end
      end
    end
    drive_byte(8'h3C, 8'hA5, 1'b1, 1'b1, s0, s1, r0, r1);
    n_cmp++;
    if ({s0, s1} !== 2'b11) begin
      n_err++; $display("FAIL lock_sync: sync=%b%b after 4th COM, required 11", s0, s1);
    end
    n_cmp++;
    if ({r0, r1} !== 2'b01) begin
      n_err++; $display("FAIL lock_rx_active: edges +0/+1 = %b%b, required 01", r0, r1);
    end
  endtask

  task automatic test_data();
    logic s0, s1, r0, r1;
    drive_byte(K, K, !STRIP, !STRIP, s0, s1, r0, r1);
    drive_byte(K, K, !STRIP, !STRIP, s0, s1, r0, r1);
    drive_byte(8'h5A, 8'hC3, 1'b1, 1'b1, s0, s1, r0, r1);
    drain();
    n_cmp++;
    if ({bus.data_0, bus.data_1} !== 16'h5AC3) begin
      n_err++; $display("FAIL data_last: %h %h, required 5a c3", bus.data_0, bus.data_1);
    end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL data_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_broken_run();
    logic s0, s1, r0, r1;
    logic [7:0] l0 [8] = '{8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h3C};
    logic [7:0] l1 [8] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      drive_byte(l0[k], l1[k], (k == 7), (k >= 4) && (l1[k] != K || !STRIP), s0, s1, r0, r1);
      n_cmp++;
      if (s0 !== (k == 7)) begin
        n_err++; $display("FAIL broken_sync0: byte %0d sync_0=%b, required %b", k, s0, (k == 7));
      end
      n_cmp++;
      if (s1 !== (k >= 4)) begin
        n_err++; $display("FAIL broken_sync1: byte %0d sync_1=%b, required %b", k, s1, (k >= 4));
      end
    end
    drain();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL broken_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_loss();
    logic s0, s1, r0, r1;
    lock_both();
    for (int k = 1; k <= 16; k++) drive_byte(K, 8'h00, !STRIP, (k <= 15), s0, s1, r0, r1);
    n_cmp++;
    if (s1 !== 1'b1) begin
      n_err++; $display("FAIL loss_early: sync_1=%b after 15 gap bytes, required 1", s1);
    end
    drive_byte(K, 8'h00, !STRIP, 1'b0, s0, s1, r0, r1);
    n_cmp++;
    if ({s0, s1} !== 2'b10) begin
      n_err++; $display("FAIL loss_sync: sync=%b%b after 16 gap bytes, required 10", s0, s1);
    end
    n_cmp++;
    if ({r0, r1} !== 2'b10) begin
      n_err++; $display("FAIL loss_rx_active: edges +0/+1 = %b%b, required 10", r0, r1);
    end
    drain();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL loss_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_enable_drop();
    logic s0, s1, r0, r1;
    lock_both();
    drive_byte(8'h11, 8'h22, 1'b1, 1'b1, s0, s1, r0, r1);
    drive_byte(8'h33, 8'h44, 1'b0, 1'b0, s0, s1, r0, r1);
    n_cmp++;
    if (r1 !== 1'b1) begin
      n_err++; $display("FAIL en_pre_active: rx_active=%b, required 1", r1);
    end
    bus.enable = 1'b0; bus.D_0 = 1'b0; bus.D_1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.sync_0, bus.sync_1, bus.valid_0, bus.valid_1, bus.rx_active} !== 5'b0) begin
      n_err++; $display("FAIL en_drop: s0 s1 v0 v1 ra = %b%b%b%b%b, required 00000",
                        bus.sync_0, bus.sync_1, bus.valid_0, bus.valid_1, bus.rx_active);
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_byte(K, K, 1'b0, 1'b0, s0, s1, r0, r1);
      if (k > 0) begin
        n_cmp++;
        if ({s0, s1} !== 2'b00) begin
          n_err++; $display("FAIL en_relock_early: byte %0d sync=%b%b, required 00", k, s0, s1);
        end
      end
    end
    drive_byte(8'h3C, 8'hA5, 1'b1, 1'b1, s0, s1, r0, r1);
    n_cmp++;
    if ({s0, s1} !== 2'b11) begin
      n_err++; $display("FAIL en_relock: sync=%b%b after 4 new COMs, required 11", s0, s1);
    end
    drain();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL en_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_async_reset();
    logic s0, s1, r0, r1;
    lock_both();
    drive_byte(8'h3C, 8'hA5, 1'b1, 1'b1, s0, s1, r0, r1);
    drain();
    n_cmp++;
    if ({bus.valid_0, bus.valid_1, bus.rx_active} !== 3'b111) begin
      n_err++; $display("FAIL areset_pre: v0 v1 ra = %b%b%b, required 111",
                        bus.valid_0, bus.valid_1, bus.rx_active);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_0, bus.data_1} !== 16'h0000) begin
      n_err++; $display("FAIL areset_data: %h %h, required 00 00", bus.data_0, bus.data_1);
    end
    n_cmp++;
    if ({bus.valid_0, bus.valid_1, bus.sync_0, bus.sync_1, bus.rx_active} !== 5'b0) begin
      n_err++; $display("FAIL areset_flags: v0 v1 s0 s1 ra = %b%b%b%b%b, required 00000",
                        bus.valid_0, bus.valid_1, bus.sync_0, bus.sync_1, bus.rx_active);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL areset_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_broken_run();
    test_loss();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phy_rx_sync_ctrl.md
# phy_rx_sync_ctrl

Two-lane receive symbol-lock controller for the PHY RX path. It samples one serial bit per lane per clock on `D_0`/`D_1` and hunts each lane for the COM symbol 0xBC to fix the byte boundary. A lane declares lock after a run of aligned COMs, and the block presents aligned bytes per lane. It sits between the lane inputs and the byte-level RX logic, and gates that logic through `rx_active`.

## Interface
- `SYNC_COMS`, 4: consecutive aligned COMs required to lock a lane (range 2–15).
- `LOSS_BYTES`, 16: consecutive aligned non-COM bytes that drop lock (range 2–255).
- `clk` input 1: single clock, all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; while low, all state clears.
- `enable` input 1: when low, both lanes are forced to HUNT on the next edge.
- `D_0`, `D_1` input 1 each: serial lane bits, MSB first.
- `data_0`, `data_1` output 8 each: last aligned byte per lane.
- `valid_0`, `valid_1` output 1 each: one-cycle pulse when the matching `data_x` updates.
- `sync_0`, `sync_1` output 1 each: lane locked.
- `rx_active` output 1: `sync_0 & sync_1 & enable`, registered.

## Operation
- Per-lane registers:
  - shift register: `sr <= {sr[6:0], D}` every edge while enabled.
  - 3-bit `phase`; the boundary is at `phase == 7`.
  - 4-bit COM counter.
  - 8-bit gap counter.
- **HUNT:** compare `sr` with 0xBC every cycle.
  - On match: go to CHECK, set COM count to 1, set `phase` to 0.
- **CHECK:** at each boundary, compare `sr`.
  - COM: increment the count. On reaching `SYNC_COMS`, go to SYNC and clear the gap counter.
  - Non-COM: go to HUNT and clear the count. The new search starts the following cycle; the failing byte is not rescanned for COM.
- **SYNC:** at each boundary, `data_x <= sr` and `valid_x` pulses (subject to Configuration).
  - COM clears the gap counter.
  - Non-COM increments the gap counter. On reaching `LOSS_BYTES`, go to HUNT, drop `sync_x`, and do not present that byte.
- The lanes are independent; there is no inter-lane deskew.
- `enable` low forces, on the next edge:
  - state to HUNT;
  - all counters to 0;
  - `valid_x` and `sync_x` to 0.
  - `sr` holds its value.
- Reset (asynchronous, any time, including mid-lock): every output is 0, `data_x` is 0x00, and `sr` is 0x00.

## Timing
- A COM whose last bit is sampled at edge N is seen in HUNT at edge N+1.
- Boundaries then fall at edges N+9, N+17, and every 8 edges after.
- `sync_x` rises at the edge that evaluates the `SYNC_COMS`-th COM. This is one edge after that COM's last bit.
- `data_x`/`valid_x` appear one edge after the last bit of the byte.
- `rx_active` follows `sync_0 & sync_1 & enable` with one cycle of latency.
- Boundary cases:
  - A COM pattern straddling a false boundary in HUNT locks to the first match.
  - In SYNC, only aligned bytes are examined.

## Configuration
- `PHY_RX_COM_STRIP_EN` defined: COM bytes in SYNC update neither `data_x` nor `valid_x`; only non-COM bytes are presented.
- Not defined: every aligned byte in SYNC, COM included, is presented.

## Structure
- Shared package `phy_rx_pkg` holds:
  - COM constant 8'hBC;
  - lane state encoding HUNT/CHECK/SYNC (2-bit);
  - counter widths.
- Sub-module `phy_rx_lane_sync` contains the per-lane shift register, phase, counters, FSM and data/valid logic. It is instantiated twice.
- The top level contains only `rx_active` and the lane instances.

## Test plan
- **Lock:** reset low for 2 cycles, then `enable`=1; both lanes carry 0xBC ×4 back-to-back from edge 1.
  - `sync_0`/`sync_1` rise after edge 33.
  - `rx_active` rises after edge 34.
- **Data:** after lock, lane 0 sends 0x3C and lane 1 sends 0xA5.
  - `data_0`=0x3C and `data_1`=0xA5 with `valid_x` pulses after edge 41.
  - 0xBC bytes produce `valid_x` only when `PHY_RX_COM_STRIP_EN` is undefined.
- **Broken run:** lane 0 sends 0xBC, 0xBC, 0x55, then 0xBC ×4.
  - Lane 0 returns to HUNT at the 0x55 boundary.
  - `sync_0` rises only after the 4th later COM.
- **Loss:** locked lane 1 receives 16 consecutive 0x00 bytes.
  - `sync_1` falls at the 16th boundary with no 16th `valid_1`.
  - `rx_active` falls one cycle later.
- **Enable drop:** `enable`=0 for one cycle mid-lock.
  - `sync_x`, `valid_x` and `rx_active` go to 0.
  - Relock requires 4 new COMs.
- **Async reset:** assert `reset`=0 between edges while locked.
  - All outputs go to 0 immediately, without waiting for a clock edge.
